// File: rtl/eeg_pea_pkg.sv
// Shared types and sizing for the PE-array output collector.
// This package is the single configuration point for the array geometry.
package eeg_pea_pkg;

  localparam int PE_ROW_DEF      = 4;
  localparam int PE_COL_DEF      = 4;
  localparam int PE_OUT_DW_DEF   = 8;
  localparam int ORAM_ADD_AW_DEF = 8;

  localparam int PE_NUM    = PE_ROW_DEF * PE_COL_DEF;
  localparam int PE_IDX_AW = $clog2(PE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One ORAM write beat: source PE index, PE-local address, data
  typedef struct packed {
    logic [PE_IDX_AW-1:0]       idx;
    logic [ORAM_ADD_AW_DEF-1:0] add;
    logic [PE_OUT_DW_DEF-1:0]   dat;
  } wr_beat_t;

endpackage

// File: rtl/eeg_rr_arb.sv
// N-way round-robin arbiter: the search starts at ptr and wraps at N-1,
// so N need not be a power of two.
module eeg_rr_arb #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  // Scan ptr, ptr+1, ... modulo N; the first requester found wins
  always_comb begin
    logic [IW:0] pos;
    pos   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && req[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

  // One-hot grant only when the caller can actually take a beat
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = en && found && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/eeg_pea_out_arb.sv
// PE-array output collector: round-robin merge of all per-PE output
// streams into one registered ORAM write port, with per-PE last-beat
// tracking and a one-cycle layer-completion pulse.
// Note: rst_n is an active-high synchronous reset despite its name.
module eeg_pea_out_arb
  import eeg_pea_pkg::*;
#(
  parameter int PE_ROW      = PE_ROW_DEF,
  parameter int PE_COL      = PE_COL_DEF,
  parameter int PE_OUT_DW   = PE_OUT_DW_DEF,
  parameter int ORAM_ADD_AW = ORAM_ADD_AW_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          CFG_START,
  input  logic [PE_ROW-1:0][PE_COL-1:0]                 PE_OUT_VLD,
  input  logic [PE_ROW-1:0][PE_COL-1:0]                 PE_OUT_LST,
  output logic [PE_ROW-1:0][PE_COL-1:0]                 PE_OUT_RDY,
  input  logic [PE_ROW-1:0][PE_COL-1:0][PE_OUT_DW-1:0]  PE_OUT_DAT,
  input  logic [PE_ROW-1:0][PE_COL-1:0][ORAM_ADD_AW-1:0] PE_OUT_ADD,
  output logic                                          ORAM_WR_VLD,
  input  logic                                          ORAM_WR_RDY,
  output logic [PE_IDX_AW+ORAM_ADD_AW-1:0]              ORAM_WR_ADD,
  output logic [PE_OUT_DW-1:0]                          ORAM_WR_DAT,
  output logic                                          LAYER_DONE,
  output logic                                          IS_IDLE
);

  // Flattened views: bit n corresponds to PE [n / PE_COL][n % PE_COL]
  logic [PE_NUM-1:0]                  vld_flat;
  logic [PE_NUM-1:0]                  lst_flat;
  logic [PE_NUM-1:0][PE_OUT_DW-1:0]   dat_flat;
  logic [PE_NUM-1:0][ORAM_ADD_AW-1:0] add_flat;

  assign vld_flat = PE_OUT_VLD;
  assign lst_flat = PE_OUT_LST;
  assign dat_flat = PE_OUT_DAT;
  assign add_flat = PE_OUT_ADD;

  state_e               state_q;
  logic [PE_NUM-1:0]    done_mask_q, done_mask_d;
  logic [PE_IDX_AW-1:0] rr_ptr_q;
  logic                 layer_done_q;
  logic                 is_idle_q;
  logic                 wr_vld_q;
  wr_beat_t             beat_q;

  logic                 can_load;
  logic                 arb_en;
  logic [PE_NUM-1:0]    arb_gnt;
  logic [PE_IDX_AW-1:0] win_idx;
  logic                 win_found;
  logic                 win_vld;

  // The output register can take a new beat when empty or being drained
  assign can_load = ~wr_vld_q | ORAM_WR_RDY;
  assign arb_en   = (state_q == ST_RUN) && can_load;
  assign win_vld  = arb_en && win_found;

  eeg_rr_arb #(
    .N  (PE_NUM),
    .IW (PE_IDX_AW)
  ) u_rr_arb (
    .req   (vld_flat & ~done_mask_q),
    .en    (arb_en),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (win_idx),
    .found (win_found)
  );

  assign PE_OUT_RDY = arb_gnt;

  // Next done mask: cleared when a layer opens, set on a granted last beat
  always_comb begin
    done_mask_d = done_mask_q;
    if (state_q == ST_IDLE && CFG_START) begin
      done_mask_d = '0;
    end else if (win_vld && lst_flat[win_idx]) begin
      done_mask_d[win_idx] = 1'b1;
    end
  end

  // Layer FSM with round-robin pointer, done mask and status outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      done_mask_q  <= '0;
      rr_ptr_q     <= '0;
      layer_done_q <= 1'b0;
      is_idle_q    <= 1'b1;
    end else begin
      done_mask_q <= done_mask_d;
      if (win_vld) begin
        rr_ptr_q <= (win_idx == PE_IDX_AW'(PE_NUM - 1)) ? '0 : win_idx + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (CFG_START) begin
            state_q   <= ST_RUN;
            is_idle_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (&done_mask_d) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!wr_vld_q || ORAM_WR_RDY) begin
            state_q      <= ST_DONE;
            layer_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          layer_done_q <= 1'b0;
          is_idle_q    <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          layer_done_q <= 1'b0;
          is_idle_q    <= 1'b1;
        end
      endcase
    end
  end

  // One-entry output register; holds its beat while ORAM stalls
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_vld_q <= 1'b0;
      beat_q   <= '0;
    end else if (can_load) begin
      wr_vld_q <= win_vld;
      if (win_vld) begin
        beat_q.idx <= win_idx;
        beat_q.add <= add_flat[win_idx];
        beat_q.dat <= dat_flat[win_idx];
      end
    end
  end

  assign ORAM_WR_VLD = wr_vld_q;
  assign ORAM_WR_ADD = {beat_q.idx, beat_q.add};
  assign ORAM_WR_DAT = beat_q.dat;
  assign LAYER_DONE  = layer_done_q;
  assign IS_IDLE     = is_idle_q;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Directed bench for the PE-array output collector.
module tb_eeg_pea_out_arb;

  localparam int NP = 16;

  logic                 clk = 1'b0;
  logic                 srst;
  logic                 cfg_start;
  logic                 wr_rdy;
  logic [NP-1:0]        vld_f;
  logic [NP-1:0]        lst_f;
  logic [NP-1:0]        rdy_f;
  logic [NP-1:0][7:0]   dat_f;
  logic [NP-1:0][7:0]   add_f;
  logic                 wr_vld;
  logic [11:0]          wr_add;
  logic [7:0]           wr_dat;
  logic                 layer_done;
  logic                 is_idle;

  always #5 clk = ~clk;

  eeg_pea_out_arb dut (
    .clk         (clk),
    .rst_n       (srst),
    .CFG_START   (cfg_start),
    .PE_OUT_VLD  (vld_f),
    .PE_OUT_LST  (lst_f),
    .PE_OUT_RDY  (rdy_f),
    .PE_OUT_DAT  (dat_f),
    .PE_OUT_ADD  (add_f),
    .ORAM_WR_VLD (wr_vld),
    .ORAM_WR_RDY (wr_rdy),
    .ORAM_WR_ADD (wr_add),
    .ORAM_WR_DAT (wr_dat),
    .LAYER_DONE  (layer_done),
    .IS_IDLE     (is_idle)
  );

  typedef struct {
    logic [7:0] add;
    logic [7:0] dat;
    logic       lst;
  } pb_t;

  typedef struct {
    logic [11:0] add;
    logic [7:0]  dat;
  } ew_t;

  pb_t pe_q[NP][$];
  ew_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt, done_cnt, done_cyc, last_wr_cyc;
  bit mask3_en = 1'b0;
  bit mask3_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int n, input logic [7:0] a, input logic [7:0] d, input logic l);
    pb_t b;
    b.add = a; b.dat = d; b.lst = l;
    pe_q[n].push_back(b);
  endtask

  task automatic expw(input int n, input logic [7:0] a, input logic [7:0] d);
    ew_t e;
    e.add = {4'(n), a};
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // Present each PE's queue head; an empty queue means VLD low
  task automatic drive();
    for (int n = 0; n < NP; n++) begin
      if (pe_q[n].size() > 0) begin
        vld_f[n] = 1'b1;
        add_f[n] = pe_q[n][0].add;
        dat_f[n] = pe_q[n][0].dat;
        lst_f[n] = pe_q[n][0].lst;
      end else begin
        vld_f[n] = 1'b0;
        add_f[n] = 8'h00;
        dat_f[n] = 8'h00;
        lst_f[n] = 1'b0;
      end
    end
  endtask

  // One clock: score the ORAM handshake, pop granted PE beats, log status
  task automatic cycle();
    logic [NP-1:0] g;
    ew_t e;
    #1;
    g = rdy_f;
    if (wr_vld && wr_rdy) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("extra_write", 32'(wr_add), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_add", 32'(wr_add), 32'(e.add));
        chk("wr_dat", 32'(wr_dat), 32'(e.dat));
        $display("write %0d: add=0x%03h dat=0x%02h", wr_cnt, wr_add, wr_dat);
      end
    end
    if (mask3_on) chk("rdy3_masked", 32'(g[3]), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    cfg_start = 1'b0;
    for (int n = 0; n < NP; n++) begin
      if (g[n] && pe_q[n].size() > 0) begin
        if (mask3_en && n == 3 && pe_q[3][0].lst) mask3_on = 1'b1;
        void'(pe_q[n].pop_front());
      end
    end
    drive();
    #1;
    if (layer_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic run_layer(input int bp_at, input int cfg_at, input int nexp);
    int budget;
    bit bp_done, cfg_done;
    logic [11:0] ha;
    logic [7:0] hd;
    budget = 0; bp_done = 1'b0; cfg_done = 1'b0;
    done_cnt = 0; wr_cnt = 0; done_cyc = -1; last_wr_cyc = -100;
    cfg_start = 1'b1;
    cycle();
    while (done_cnt == 0 && budget < 300) begin
      if (!bp_done && bp_at >= 0 && wr_cnt == bp_at && wr_vld) begin
        wr_rdy = 1'b0;
        ha = wr_add;
        hd = wr_dat;
        for (int k = 0; k < 5; k++) begin
          cycle();
          chk("bp_add", 32'(wr_add), 32'(ha));
          chk("bp_dat", 32'(wr_dat), 32'(hd));
          chk("bp_vld", 32'(wr_vld), 32'd1);
          chk("bp_rdy", 32'(rdy_f), 32'd0);
        end
        wr_rdy = 1'b1;
        bp_done = 1'b1;
      end
      if (!cfg_done && cfg_at >= 0 && wr_cnt == cfg_at) begin
        cfg_start = 1'b1;
        cfg_done = 1'b1;
      end
      cycle();
      budget++;
      if (wr_cnt >= 1 && wr_cnt < nexp) chk("no_bubble", 32'(wr_vld), 32'd1);
    end
    if (done_cnt == 0) chk("layer_timeout", 32'd0, 32'd1);
    cycle();
    cycle();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("writes_total", 32'(wr_cnt), 32'(nexp));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("idle_after", 32'(is_idle), 32'd1);
    $display("layer end: writes=%0d done_pulses=%0d", wr_cnt, done_cnt);
    mask3_on = 1'b0;
  endtask

  initial begin
    srst = 1'b1; cfg_start = 1'b0; wr_rdy = 1'b1;
    drive();
    vld_f = '1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_vld", 32'(wr_vld), 32'd0);
    chk("rst_add", 32'(wr_add), 32'd0);
    chk("rst_dat", 32'(wr_dat), 32'd0);
    chk("rst_done", 32'(layer_done), 32'd0);
    chk("rst_idle", 32'(is_idle), 32'd1);
    chk("rst_rdy", 32'(rdy_f), 32'd0);
    srst = 1'b0;
    drive();
    cycle();
    chk("idle_hold", 32'(is_idle), 32'd1);

    // Layer A: PE 5 sends three beats, everyone else one last beat; ptr starts at 0
    for (int n = 0; n < NP; n++) begin
      if (n == 5) begin
        push(5, 8'd0, 8'h11, 1'b0);
        push(5, 8'd1, 8'h22, 1'b0);
        push(5, 8'd2, 8'h33, 1'b1);
      end else begin
        push(n, 8'(n), 8'(8'hA0 + n), 1'b1);
      end
    end
    for (int n = 0; n < 5; n++) expw(n, 8'(n), 8'(8'hA0 + n));
    expw(5, 8'd0, 8'h11);
    for (int n = 6; n < NP; n++) expw(n, 8'(n), 8'(8'hA0 + n));
    expw(5, 8'd1, 8'h22);
    expw(5, 8'd2, 8'h33);
    drive();
    run_layer(-1, -1, 18);

    // Layer B: all PEs busy, three beats each; ptr resumes at 6 after PE 5.
    // Backpressure after 10 writes, stray CFG_START after 40.
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < NP; n++)
        push(n, 8'(k * 16 + n), 8'(8'h40 + n * 3 + k), (k == 2));
    begin
      int cnt[NP];
      for (int n = 0; n < NP; n++) cnt[n] = 0;
      for (int i = 0; i < 48; i++) begin
        int n;
        n = (6 + i) % NP;
        expw(n, 8'(cnt[n] * 16 + n), 8'(8'h40 + n * 3 + cnt[n]));
        cnt[n]++;
      end
    end
    drive();
    run_layer(10, 40, 48);

    // Layer C: PE 3 raises VLD again after its last beat; PE 8 keeps going
    push(3, 8'h30, 8'h33, 1'b1);
    push(3, 8'h31, 8'h3F, 1'b1);
    for (int k = 0; k < 4; k++) push(8, 8'(8'h80 + k), 8'(8'h88 + k), (k == 3));
    for (int n = 0; n < NP; n++)
      if (n != 3 && n != 8) push(n, 8'(n), 8'(8'hC0 + n), 1'b1);
    expw(6, 8'd6, 8'hC6);
    expw(7, 8'd7, 8'hC7);
    expw(8, 8'h80, 8'h88);
    for (int n = 9; n < NP; n++) expw(n, 8'(n), 8'(8'hC0 + n));
    for (int n = 0; n < 3; n++) expw(n, 8'(n), 8'(8'hC0 + n));
    expw(3, 8'h30, 8'h33);
    expw(4, 8'd4, 8'hC4);
    expw(5, 8'd5, 8'hC5);
    expw(8, 8'h81, 8'h89);
    expw(8, 8'h82, 8'h8A);
    expw(8, 8'h83, 8'h8B);
    mask3_en = 1'b1;
    drive();
    run_layer(-1, -1, 19);
    mask3_en = 1'b0;
    chk("idle_rdy", 32'(rdy_f), 32'd0);
    chk("pe3_held", 32'(pe_q[3].size()), 32'd1);

    // Layer D: reset while a beat (PE 9, ptr after PE 8) sits in the register
    for (int n = 0; n < NP; n++)
      if (n != 3) push(n, 8'(n), 8'(8'hD0 + n), 1'b1);
    drive();
    wr_rdy = 1'b0;
    cfg_start = 1'b1;
    cycle();
    cycle();
    chk("pre_rst_vld", 32'(wr_vld), 32'd1);
    chk("pre_rst_add", 32'(wr_add), 32'h909);
    srst = 1'b1;
    cycle();
    srst = 1'b0;
    chk("post_rst_vld", 32'(wr_vld), 32'd0);
    chk("post_rst_idle", 32'(is_idle), 32'd1);
    chk("post_rst_add", 32'(wr_add), 32'd0);
    wr_rdy = 1'b1;
    cycle();
    cycle();
    chk("post_rst_stay", 32'(is_idle), 32'd1);

    // Layer E: clean layer after reset; ptr back at 0, PE 9 resends
    push(9, 8'h99, 8'hE9, 1'b1);
    for (int n = 0; n < NP; n++) begin
      if (n == 3) expw(3, 8'h31, 8'h3F);
      else if (n == 9) expw(9, 8'h99, 8'hE9);
      else expw(n, 8'(n), 8'(8'hD0 + n));
    end
    drive();
    run_layer(-1, -1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
